// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the five-stage MIPS pipeline: ALU operation codes,
// the decoded control bundle carried down the pipe, and register constants.
package cpu_defs;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11,
        ALU_R12  = 4'd12,
        ALU_R13  = 4'd13,
        ALU_R14  = 4'd14,
        ALU_R15  = 4'd15
    } alu_op_e;

    // Bit offsets of each field inside the packed control bundle.
    localparam int unsigned CTRL_ALUOP_LSB = 0;
    localparam int unsigned CTRL_ALUSRC    = 4;
    localparam int unsigned CTRL_MEMTOREG  = 5;
    localparam int unsigned CTRL_MEMWRITE  = 6;
    localparam int unsigned CTRL_MEMREAD   = 7;
    localparam int unsigned CTRL_REGWRITE  = 8;
    localparam int unsigned CTRL_W         = 9;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    // A bubble carries no side effects: no register write, no memory access.
    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic ctrl_t make_ctrl(
        input logic       reg_write,
        input logic       mem_read,
        input logic       mem_write,
        input logic       mem_to_reg,
        input logic       alu_src,
        input logic [3:0] alu_op
    );
        ctrl_t c;
        c.reg_write  = reg_write;
        c.mem_read   = mem_read;
        c.mem_write  = mem_write;
        c.mem_to_reg = mem_to_reg;
        c.alu_src    = alu_src;
        c.alu_op     = alu_op_e'(alu_op);
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detection: the load in EX writes a register the ID
// instruction reads, so the consumer must wait one cycle for the load data.
module load_use_detect
    import cpu_defs::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    logic rs_match;
    logic rt_match;

    // Compare the load destination against the ID sources; $0 never hazards.
    always_comb begin
        rs_match = (ex_rt == id_rs);
        rt_match = id_uses_rt && (ex_rt == id_rt);
        load_use = ex_valid && ex_mem_read && id_valid && (ex_rt != REG_ZERO)
                   && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, downstream
// hold and a saturating count of inserted bubbles.
module id_ex_stage
    import cpu_defs::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [4:0]        IF_ID_RegisterRs,
    input  logic [4:0]        IF_ID_RegisterRt,
    input  logic              ID_UsesRt,
    input  logic [4:0]        ID_RegisterRd,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic              ID_Valid,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemToReg,
    input  logic              ID_ALUSrc,
    input  logic [3:0]        ID_ALUOp,
    input  logic              EX_Flush,
    input  logic              MEM_Hold,
    output logic [4:0]        ID_EX_RegisterRs,
    output logic [4:0]        ID_EX_RegisterRt,
    output logic [4:0]        ID_EX_RegisterRd,
    output logic [DATA_W-1:0] ID_EX_ReadData1,
    output logic [DATA_W-1:0] ID_EX_ReadData2,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_MemToReg,
    output logic              ID_EX_ALUSrc,
    output logic [3:0]        ID_EX_ALUOp,
    output logic              ID_EX_Valid,
    output logic              Stall,
    output logic [CNT_W-1:0]  BubbleCount
);

    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;

    logic load_use;
    logic clear;
    logic count;

    load_use_detect u_load_use_detect (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (rt_q),
        .id_valid    (ID_Valid),
        .id_rs       (IF_ID_RegisterRs),
        .id_rt       (IF_ID_RegisterRt),
        .id_uses_rt  (ID_UsesRt),
        .load_use    (load_use)
    );

    // Upstream freeze; forced low in reset so PC/IF-ID are never held by a
    // MEM_Hold that arrives before the pipe is running.
    always_comb begin
        Stall = RST_N && (load_use || MEM_Hold) && !EX_Flush;
    end

    // Per-edge action: flush > hold > load-use bubble > load (or idle bubble).
    always_comb begin
        rs_d           = rs_q;
        rt_d           = rt_q;
        rd_d           = rd_q;
        rd1_d          = rd1_q;
        rd2_d          = rd2_q;
        imm_d          = imm_q;
        ctrl_d         = ctrl_q;
        valid_d        = valid_q;
        bubble_count_d = bubble_count_q;
        clear          = 1'b0;
        count          = 1'b0;

        if (EX_Flush) begin
            clear = 1'b1;
            count = 1'b1;
        end else if (MEM_Hold) begin
            clear = 1'b0;
        end else if (load_use) begin
            clear = 1'b1;
            count = 1'b1;
        end else if (ID_Valid) begin
            rs_d    = IF_ID_RegisterRs;
            rt_d    = IF_ID_RegisterRt;
            rd_d    = ID_RegisterRd;
            rd1_d   = ID_ReadData1;
            rd2_d   = ID_ReadData2;
            imm_d   = ID_Imm;
            ctrl_d  = make_ctrl(ID_RegWrite, ID_MemRead, ID_MemWrite,
                                ID_MemToReg, ID_ALUSrc, ID_ALUOp);
            valid_d = 1'b1;
        end else begin
            clear = 1'b1;
        end

        if (clear) begin
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
        end

        if (count && (bubble_count_q != '1)) begin
            bubble_count_d = bubble_count_q + CNT_W'(1);
        end
    end

    // Stage register and bubble counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rs_q           <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
            rd1_q          <= '0;
            rd2_q          <= '0;
            imm_q          <= '0;
            ctrl_q         <= CTRL_BUBBLE;
            valid_q        <= 1'b0;
            bubble_count_q <= '0;
        end else begin
            rs_q           <= rs_d;
            rt_q           <= rt_d;
            rd_q           <= rd_d;
            rd1_q          <= rd1_d;
            rd2_q          <= rd2_d;
            imm_q          <= imm_d;
            ctrl_q         <= ctrl_d;
            valid_q        <= valid_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    // Output mapping from the stage register.
    always_comb begin
        ID_EX_RegisterRs = rs_q;
        ID_EX_RegisterRt = rt_q;
        ID_EX_RegisterRd = rd_q;
        ID_EX_ReadData1  = rd1_q;
        ID_EX_ReadData2  = rd2_q;
        ID_EX_Imm        = imm_q;
        ID_EX_RegWrite   = ctrl_q.reg_write;
        ID_EX_MemRead    = ctrl_q.mem_read;
        ID_EX_MemWrite   = ctrl_q.mem_write;
        ID_EX_MemToReg   = ctrl_q.mem_to_reg;
        ID_EX_ALUSrc     = ctrl_q.alu_src;
        ID_EX_ALUOp      = ctrl_q.alu_op;
        ID_EX_Valid      = valid_q;
        BubbleCount      = bubble_count_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: instruction-level model plus directed
// program fragments with hand-computed expectations.
module tb_id_ex_stage;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [4:0]  IF_ID_RegisterRs = '0, IF_ID_RegisterRt = '0, ID_RegisterRd = '0;
    logic        ID_UsesRt = 1'b0;
    logic [31:0] ID_ReadData1 = '0, ID_ReadData2 = '0, ID_Imm = '0;
    logic        ID_Valid = 1'b0, ID_RegWrite = 1'b0, ID_MemRead = 1'b0;
    logic        ID_MemWrite = 1'b0, ID_MemToReg = 1'b0, ID_ALUSrc = 1'b0;
    logic [3:0]  ID_ALUOp = '0;
    logic        EX_Flush = 1'b0, MEM_Hold = 1'b0;
    logic [4:0]  ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd;
    logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm;
    logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc;
    logic [3:0]  ID_EX_ALUOp;
    logic        ID_EX_Valid, Stall;
    logic [15:0] BubbleCount;

    int checks = 0;
    int failures = 0;

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
        .ID_UsesRt(ID_UsesRt), .ID_RegisterRd(ID_RegisterRd),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
        .ID_Valid(ID_Valid), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc),
        .ID_ALUOp(ID_ALUOp), .EX_Flush(EX_Flush), .MEM_Hold(MEM_Hold),
        .ID_EX_RegisterRs(ID_EX_RegisterRs), .ID_EX_RegisterRt(ID_EX_RegisterRt),
        .ID_EX_RegisterRd(ID_EX_RegisterRd), .ID_EX_ReadData1(ID_EX_ReadData1),
        .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_Imm(ID_EX_Imm),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemToReg(ID_EX_MemToReg),
        .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp),
        .ID_EX_Valid(ID_EX_Valid), .Stall(Stall), .BubbleCount(BubbleCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic        uses_rt;
        logic [31:0] d1, d2, imm;
        logic        v, rw, mr, mw, mtr, as;
        logic [3:0]  op;
    } instr_t;

    // What EX holds: an instruction (or nothing), as the model sees it.
    instr_t ex_m;
    int     bubbles_m;

    function automatic instr_t nothing();
        instr_t i;
        i.rs = 0; i.rt = 0; i.rd = 0; i.uses_rt = 0;
        i.d1 = 0; i.d2 = 0; i.imm = 0;
        i.v = 0; i.rw = 0; i.mr = 0; i.mw = 0; i.mtr = 0; i.as = 0; i.op = 0;
        return i;
    endfunction

    function automatic instr_t mk_lw(input logic [4:0] rt, input logic [4:0] rs, input logic [31:0] off);
        instr_t i = nothing();
        i.rs = rs; i.rt = rt; i.rd = rt; i.imm = off;
        i.d1 = 32'h1000_0000 + 32'(rs); i.d2 = 32'h2000_0000 + 32'(rt);
        i.v = 1; i.rw = 1; i.mr = 1; i.mtr = 1; i.as = 1; i.op = 4'd0;
        return i;
    endfunction

    function automatic instr_t mk_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        instr_t i = nothing();
        i.rs = rs; i.rt = rt; i.rd = rd; i.uses_rt = 1;
        i.d1 = 32'hA000_0000 + 32'(rs); i.d2 = 32'hB000_0000 + 32'(rt); i.imm = 32'hFFFF_FFF0;
        i.v = 1; i.rw = 1; i.op = 4'd6;
        return i;
    endfunction

    function automatic instr_t mk_sw(input logic [4:0] rt, input logic [4:0] rs, input logic [31:0] off);
        instr_t i = nothing();
        i.rs = rs; i.rt = rt; i.uses_rt = 1; i.imm = off;
        i.d1 = 32'hC000_0000 + 32'(rs); i.d2 = 32'hD000_0000 + 32'(rt);
        i.v = 1; i.mw = 1; i.as = 1; i.op = 4'd0;
        return i;
    endfunction

    function automatic instr_t mk_nop();
        instr_t i = nothing();
        i.v = 1;
        return i;
    endfunction

    function automatic instr_t id_now();
        instr_t i;
        i.rs = IF_ID_RegisterRs; i.rt = IF_ID_RegisterRt; i.rd = ID_RegisterRd;
        i.uses_rt = ID_UsesRt; i.d1 = ID_ReadData1; i.d2 = ID_ReadData2; i.imm = ID_Imm;
        i.v = ID_Valid; i.rw = ID_RegWrite; i.mr = ID_MemRead; i.mw = ID_MemWrite;
        i.mtr = ID_MemToReg; i.as = ID_ALUSrc; i.op = ID_ALUOp;
        return i;
    endfunction

    // The instruction in ID needs a register the load in EX has not produced yet.
    function automatic logic waits_on_load(input instr_t ex, input instr_t id);
        if (!(ex.v && ex.mr && id.v) || ex.rt == 5'd0) return 1'b0;
        return (id.rs == ex.rt) || (id.uses_rt && id.rt == ex.rt);
    endfunction

    // Model: what occupies EX after each edge, and how many bubbles so far.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_m = nothing();
            bubbles_m = 0;
        end else if (EX_Flush) begin
            ex_m = nothing();
            if (bubbles_m < 65535) bubbles_m++;
        end else if (!MEM_Hold) begin
            if (waits_on_load(ex_m, id_now())) begin
                ex_m = nothing();
                if (bubbles_m < 65535) bubbles_m++;
            end else begin
                ex_m = ID_Valid ? id_now() : nothing();
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle, mid-period.
    always @(negedge CLK) begin
        logic exp_stall;
        exp_stall = RST_N && !EX_Flush && (MEM_Hold || waits_on_load(ex_m, id_now()));
        check("specifiers", 128'({ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd}),
              128'({ex_m.rs, ex_m.rt, ex_m.rd}));
        check("data", 128'({ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm}),
              128'({ex_m.d1, ex_m.d2, ex_m.imm}));
        check("control", 128'({ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg,
                               ID_EX_ALUSrc, ID_EX_ALUOp}),
              128'({ex_m.rw, ex_m.mr, ex_m.mw, ex_m.mtr, ex_m.as, ex_m.op}));
        check("valid", 128'(ID_EX_Valid), 128'(ex_m.v));
        check("stall", 128'(Stall), 128'(exp_stall));
        check("bubble_count", 128'(BubbleCount), 128'(bubbles_m));
    end

    task automatic drive(input instr_t i);
        IF_ID_RegisterRs = i.rs; IF_ID_RegisterRt = i.rt; ID_RegisterRd = i.rd;
        ID_UsesRt = i.uses_rt; ID_ReadData1 = i.d1; ID_ReadData2 = i.d2; ID_Imm = i.imm;
        ID_Valid = i.v; ID_RegWrite = i.rw; ID_MemRead = i.mr; ID_MemWrite = i.mw;
        ID_MemToReg = i.mtr; ID_ALUSrc = i.as; ID_ALUOp = i.op;
    endtask

    // Hold the instruction in ID until it is accepted; report stalled edges.
    task automatic present(input instr_t i, output int stalls);
        logic st;
        drive(i);
        stalls = 0;
        forever begin
            #1 st = Stall;
            @(posedge CLK);
            #1;
            if (!st) break;
            stalls++;
            check("stall_bubble_valid", 128'(ID_EX_Valid), 128'(0));
            check("stall_bubble_regwrite", 128'(ID_EX_RegWrite), 128'(0));
            if (stalls > 8) begin
                check("stall_bound", 128'(stalls), 128'(1));
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int s;
        // Reset state
        #2 MEM_Hold = 1'b1;
        #1;
        check("reset_stall", 128'(Stall), 128'(0));
        check("reset_valid", 128'(ID_EX_Valid), 128'(0));
        check("reset_count", 128'(BubbleCount), 128'(0));
        MEM_Hold = 1'b0;
        repeat (2) @(posedge CLK);
        #3 RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // lw $2,0($1); add $4,$2,$3 : one bubble
        present(mk_lw(5'd2, 5'd1, 32'd0), s);
        check("lw_stalls", 128'(s), 128'(0));
        present(mk_add(5'd4, 5'd2, 5'd3), s);
        check("lw_add_stalls", 128'(s), 128'(1));
        check("add_in_ex_rd", 128'(ID_EX_RegisterRd), 128'(4));
        check("add_in_ex_valid", 128'(ID_EX_Valid), 128'(1));
        check("count_after_lw_add", 128'(BubbleCount), 128'(1));

        // lw $2; sw $2,4($5) : rt-side hazard
        present(mk_lw(5'd2, 5'd1, 32'd8), s);
        present(mk_sw(5'd2, 5'd5, 32'd4), s);
        check("lw_sw_stalls", 128'(s), 128'(1));
        check("count_after_lw_sw", 128'(BubbleCount), 128'(2));

        // lw $0; add $4,$0,$3 : never stalls
        present(mk_lw(5'd0, 5'd1, 32'd0), s);
        present(mk_add(5'd4, 5'd0, 5'd3), s);
        check("lw0_stalls", 128'(s), 128'(0));
        check("count_after_lw0", 128'(BubbleCount), 128'(2));

        // Empty ID slot: bubble without counting
        present(nothing(), s);
        check("idle_valid", 128'(ID_EX_Valid), 128'(0));
        check("idle_count", 128'(BubbleCount), 128'(2));

        // lw $2; nop; add $4,$2,$3 : covered by forwarding
        present(mk_lw(5'd2, 5'd1, 32'd0), s);
        present(mk_nop(), s);
        present(mk_add(5'd4, 5'd2, 5'd3), s);
        check("lw_nop_add_stalls", 128'(s), 128'(0));

        // Downstream hold for three cycles with an add in EX
        present(mk_add(5'd7, 5'd8, 5'd9), s);
        drive(mk_add(5'd10, 5'd11, 5'd12));
        MEM_Hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold_stall", 128'(Stall), 128'(1));
            @(posedge CLK);
            #1;
            check("hold_rd", 128'(ID_EX_RegisterRd), 128'(7));
            check("hold_data1", 128'(ID_EX_ReadData1), 128'(32'hA000_0008));
        end
        MEM_Hold = 1'b0;
        @(posedge CLK);
        #1;
        check("after_hold_rd", 128'(ID_EX_RegisterRd), 128'(10));

        // Load-use and flush together: single bubble, no stall
        present(mk_lw(5'd2, 5'd1, 32'd0), s);
        drive(mk_add(5'd4, 5'd2, 5'd3));
        EX_Flush = 1'b1;
        #1;
        check("flush_lu_stall", 128'(Stall), 128'(0));
        @(posedge CLK);
        #1;
        EX_Flush = 1'b0;
        check("flush_lu_valid", 128'(ID_EX_Valid), 128'(0));
        check("flush_lu_count", 128'(BubbleCount), 128'(3));

        // Flush wins over hold
        present(mk_add(5'd13, 5'd14, 5'd15), s);
        drive(mk_nop());
        MEM_Hold = 1'b1;
        EX_Flush = 1'b1;
        @(posedge CLK);
        #1;
        check("flush_hold_valid", 128'(ID_EX_Valid), 128'(0));
        check("flush_hold_regwrite", 128'(ID_EX_RegWrite), 128'(0));
        check("flush_hold_count", 128'(BubbleCount), 128'(4));
        EX_Flush = 1'b0;
        MEM_Hold = 1'b0;

        // Asynchronous reset between edges, then clean restart
        present(mk_add(5'd20, 5'd21, 5'd22), s);
        #2;
        MEM_Hold = 1'b1;
        RST_N = 1'b0;
        #1;
        check("midreset_valid", 128'(ID_EX_Valid), 128'(0));
        check("midreset_rd", 128'(ID_EX_RegisterRd), 128'(0));
        check("midreset_count", 128'(BubbleCount), 128'(0));
        check("midreset_stall", 128'(Stall), 128'(0));
        MEM_Hold = 1'b0;
        @(posedge CLK);
        #3 RST_N = 1'b1;
        present(mk_add(5'd5, 5'd6, 5'd7), s);
        check("restart_rd", 128'(ID_EX_RegisterRd), 128'(5));
        check("restart_valid", 128'(ID_EX_Valid), 128'(1));

        // Saturation of the bubble counter
        EX_Flush = 1'b1;
        repeat (65540) @(posedge CLK);
        #1;
        check("saturated_count", 128'(BubbleCount), 128'(16'hFFFF));
        EX_Flush = 1'b0;
        @(posedge CLK);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register of the five-stage MIPS CPU, with integrated load-use hazard detection, bubble insertion, flush and downstream hold.
- Registers decoded operands, immediate, register specifiers and control from ID.
- Presents the ID_EX_* values that the EX forwarding muxes and the forwarding unit consume.
- Generates the upstream stall that freezes PC and the IF/ID register.

Parameters:
DATA_W, 32, operand/immediate width
CNT_W, 16, width of saturating bubble counter

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
IF_ID_RegisterRs  in  5  rs of instruction in ID
IF_ID_RegisterRt  in  5  rt of instruction in ID
ID_UsesRt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
ID_RegisterRd  in  5  destination already selected in ID (rd or rt)
ID_ReadData1  in  DATA_W  register file port 1
ID_ReadData2  in  DATA_W  register file port 2
ID_Imm  in  DATA_W  sign/zero-extended immediate
ID_Valid  in  1  ID holds a real instruction
ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc  in  1 each  decoded control
ID_ALUOp  in  4  ALU operation
EX_Flush  in  1  taken branch/jump resolved; kill ID instruction
MEM_Hold  in  1  downstream busy; freeze this stage
ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd  out  5  registered specifiers
ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm  out  DATA_W  registered data
ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc  out  1 each  registered control
ID_EX_ALUOp  out  4  registered ALU op
ID_EX_Valid  out  1  EX holds a real instruction
Stall  out  1  combinational; freeze PC and IF/ID
BubbleCount  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset (RST_N=0, asynchronous): all registered outputs 0, including ID_EX_Valid=0 and BubbleCount=0. Stall=0 during reset.
- LoadUse (combinational) = ID_EX_Valid & ID_EX_MemRead & ID_Valid & (ID_EX_RegisterRt != 0) & ((ID_EX_RegisterRt == IF_ID_RegisterRs) | (ID_UsesRt & ID_EX_RegisterRt == IF_ID_RegisterRt)).
- Stall = (LoadUse | MEM_Hold) & !EX_Flush.
- Per-edge action, priority highest first:
  1. EX_Flush: load bubble, i.e. all control outputs 0 and ID_EX_Valid=0. Data and specifier fields are don't-care, but the implementation loads 0. Flush overrides hold.
  2. MEM_Hold: all registers keep their value.
  3. LoadUse: load bubble as above. The ID instruction is retained upstream through Stall and re-presented next cycle; LoadUse then clears because ID_EX_MemRead=0.
  4. Otherwise: load all ID_* inputs. A bubble is loaded, not the inputs, when ID_Valid=0.
- Latency: 1 cycle ID to EX. A load-use costs exactly 1 bubble.
- BubbleCount increments by 1 on each edge taking action 1 or 3. It does not increment on hold or on ID_Valid=0 loads. It saturates at all-ones, with no wrap.
- A bubble never asserts RegWrite or MemWrite, so the forwarding unit never matches it.
- Load with rt=0 never stalls.
- A load followed by a consumer two slots later is handled by forwarding: no stall.
- Reset deasserting mid-stream: the first edge after release loads normally.

Decomposition:
- Shared package, cpu_defs: ALUOp encodings, control-bundle field offsets, REG_ZERO=5'd0.
- Natural sub-module: load_use_detect, the combinational LoadUse equation.
- Pipeline register and counter stay in id_ex_stage.

Test Plan:
- lw $2,0($1); add $4,$2,$3 -> Stall=1 for one cycle. Next EX cycle ID_EX_Valid=0, ID_EX_RegWrite=0. Add enters EX the following cycle. BubbleCount=1.
- lw $2,0($1); sw $2,4($5) (ID_UsesRt=1) -> one stall. lw $0,0($1); add $4,$0,$3 -> no stall, BubbleCount unchanged.
- lw $2; nop; add $4,$2,$3 -> Stall never asserts.
- Hold: MEM_Hold=1 for 3 cycles with add in EX -> ID_EX_* constant and Stall=1 throughout. The next instruction loads on the first edge after release.
- LoadUse and EX_Flush in the same cycle -> Stall=0, bubble loaded, BubbleCount +1 (not +2). EX_Flush during MEM_Hold -> bubble loaded.
- Assert RST_N=0 mid-program between edges -> outputs 0 immediately. Force 65536 bubbles with CNT_W=16 -> BubbleCount=16'hFFFF, holds.
